// File: rtl/multiword_add_seq.sv
// rtl/multiword_add_seq.sv - chunk-serial wide add/subtract sequencer driving an external SIZE-bit adder
module multiword_add_seq #(
    parameter int SIZE  = 8,
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SIZE*WORDS-1:0]   op_a,
    input  logic [SIZE*WORDS-1:0]   op_b,
    input  logic                    sub,
    output logic [SIZE-1:0]         add_a,
    output logic [SIZE-1:0]         add_b,
    output logic                    add_cin,
    input  logic [SIZE-1:0]         add_sum,
    input  logic                    add_cout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SIZE*WORDS-1:0]   result,
    output logic                    carry_out,
    output logic                    overflow
);

    localparam int W    = SIZE * WORDS;
    localparam int IDXW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDXW-1:0]   idx;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic              carry_reg;
    logic              last;

    assign last = (idx == IDXW'(WORDS - 1));

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = '0;
        add_b      = '0;
        add_cin    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                add_a   = a_reg[idx*SIZE +: SIZE];
                add_b   = b_reg[idx*SIZE +: SIZE];
                add_cin = carry_reg;
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract as A + ~B + 1: the +1 enters as the first chunk's carry-in
                        a_reg     <= op_a;
                        b_reg     <= sub ? ~op_b : op_b;
                        carry_reg <= sub;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    result[idx*SIZE +: SIZE] <= add_sum;
                    carry_reg                <= add_cout;
                    if (last) begin
                        carry_out <= add_cout;
                        overflow  <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[SIZE-1] != a_reg[W-1]);
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
